// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared state encoding, counter-width helper and iteration guard limit for the GF(2^M) divider
package gf2m_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
  function automatic int guard_limit(input int m);
    return 2 * m;
  endfunction
endpackage

// File: rtl/gf2m_div_step.sv
// gf2m_div_step: one combinational binary-Euclid iteration; a/b/u/v/ca/cb/f in, a_n/b_n/u_n/v_n/ca_n/cb_n/frozen out
module gf2m_div_step #(
  parameter int M = 256,
  parameter int CW = 11
) (
  input  logic [M:0]           a,
  input  logic [M:0]           b,
  input  logic [M:0]           u,
  input  logic [M:0]           v,
  input  logic [M:0]           f,
  input  logic signed [CW-1:0] ca,
  input  logic signed [CW-1:0] cb,
  output logic [M:0]           a_n,
  output logic [M:0]           b_n,
  output logic [M:0]           u_n,
  output logic [M:0]           v_n,
  output logic signed [CW-1:0] ca_n,
  output logic signed [CW-1:0] cb_n,
  output logic                 frozen
);
  localparam logic [M:0] ONE = (M+1)'(1);
  localparam logic signed [CW-1:0] DEC = CW'(1);
  function automatic logic [M:0] halve(input logic [M:0] t, input logic [M:0] p);
    return (t[0] ? t ^ p : t) >> 1;
  endfunction
  logic [M:0] ab, uv;
  assign ab = (a ^ b) >> 1;
  assign uv = halve(u ^ v, f);
  assign frozen = a == ONE;
  always_comb begin
    a_n = a;
    b_n = b;
    u_n = u;
    v_n = v;
    ca_n = ca;
    cb_n = cb;
    if (!frozen) begin
      if (!a[0]) begin
        a_n = a >> 1;
        u_n = halve(u, f);
        ca_n = ca - DEC;
      end else if (!b[0]) begin
        b_n = b >> 1;
        v_n = halve(v, f);
        cb_n = cb - DEC;
      end else if (ca > cb) begin
        a_n = ab;
        u_n = uv;
        ca_n = ca - DEC;
      end else begin
        b_n = ab;
        v_n = uv;
        cb_n = cb - DEC;
      end
    end
  end
endmodule

// File: rtl/gf2m_divider.sv
// gf2m_divider: y/x (or 1/x) mod poly by binary Euclid, STEPS iterations/clk; in clk reset start inv poly y x, out busy done err result (+cycles under GF2M_DIVIDER_CYCLE_COUNT_EN)
module gf2m_divider
  import gf2m_pkg::*;
#(
  parameter int M = 256,
  parameter int STEPS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         inv,
  input  logic [M:0]   poly,
  input  logic [M-1:0] y,
  input  logic [M-1:0] x,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [M-1:0] result
`ifdef GF2M_DIVIDER_CYCLE_COUNT_EN
  ,
  output logic [cnt_w(2*M+2)-1:0] cycles
`endif
);
  localparam int CW = cnt_w(M + 1) + 1;
  localparam int IW = cnt_w(2 * M + 1);
  localparam logic [M:0] ONE = (M+1)'(1);
  localparam logic [IW-1:0] GUARD = IW'(guard_limit(M));
  state_t state, state_n;
  logic [M:0] a, b, u, v, f;
  logic signed [CW-1:0] ca, cb;
  logic [IW-1:0] it;
  logic [M:0] ac [STEPS+1];
  logic [M:0] bc [STEPS+1];
  logic [M:0] uc [STEPS+1];
  logic [M:0] vc [STEPS+1];
  logic signed [CW-1:0] cac [STEPS+1];
  logic signed [CW-1:0] cbc [STEPS+1];
  logic [IW-1:0] itc [STEPS+1];
  logic [STEPS-1:0] fz;
  logic go, hit;
  assign ac[0] = a;
  assign bc[0] = b;
  assign uc[0] = u;
  assign vc[0] = v;
  assign cac[0] = ca;
  assign cbc[0] = cb;
  assign itc[0] = it;
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    gf2m_div_step #(.M(M), .CW(CW)) u_step (
      .a(ac[g]), .b(bc[g]), .u(uc[g]), .v(vc[g]), .f(f), .ca(cac[g]), .cb(cbc[g]),
      .a_n(ac[g+1]), .b_n(bc[g+1]), .u_n(uc[g+1]), .v_n(vc[g+1]),
      .ca_n(cac[g+1]), .cb_n(cbc[g+1]), .frozen(fz[g])
    );
    assign itc[g+1] = itc[g] + IW'(!fz[g]);
  end
  assign go = state == IDLE && start;
  assign hit = ac[STEPS] == ONE;
  always_comb begin
    busy = state == RUN;
    done = state == FIN;
    state_n = state == IDLE ? (start ? (x == '0 ? FIN : RUN) : IDLE)
            : state == RUN  ? (hit || itc[STEPS] >= GUARD ? FIN : RUN)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      u <= '0;
      v <= '0;
      f <= '0;
      ca <= '0;
      cb <= '0;
      it <= '0;
      err <= 1'b0;
      result <= '0;
    end else begin
      state <= state_n;
      if (go) begin
        a <= {1'b0, x};
        b <= poly;
        f <= poly;
        u <= inv ? ONE : {1'b0, y};
        v <= '0;
        ca <= CW'(M - 1);
        cb <= CW'(M);
        it <= '0;
        if (x == '0) begin
          err <= 1'b1;
          result <= '0;
        end
      end else if (busy) begin
        a <= ac[STEPS];
        b <= bc[STEPS];
        u <= uc[STEPS];
        v <= vc[STEPS];
        ca <= cac[STEPS];
        cb <= cbc[STEPS];
        it <= itc[STEPS];
        if (state_n == FIN) begin
          err <= !hit;
          result <= hit ? uc[STEPS][M-1:0] : '0;
        end
      end
    end
  end
`ifdef GF2M_DIVIDER_CYCLE_COUNT_EN
  localparam int CYW = cnt_w(2 * M + 2);
  always_ff @(posedge clk) begin
    if (reset || go) cycles <= '0;
    else if (busy) cycles <= cycles + CYW'(1);
  end
`endif
endmodule

// File: tb/tb_gf2m_divider.sv
// tb_gf2m_divider: scoreboard bench for gf2m_divider at M=8/STEPS=1 and M=163/STEPS=8 against a field-exponentiation model
module tb_gf2m_divider;
  localparam int W = 164;
  localparam int MA = 8, SA = 1, MB = 163, SB = 8;
  localparam int HA = 2 + (2 * MA + SA - 1) / SA;
  localparam int HB = 2 + (2 * MB + SB - 1) / SB;
  localparam logic [MA:0] PA = 9'h11B;
  localparam logic [MB:0] PB = (164'd1 << 163) | 164'hC9;
  typedef struct {logic [W-1:0] ex; logic ee; int t0; int lo; int hi;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic start_a = 1'b0, inv_a = 1'b0, busy_a, done_a, err_a;
  logic [MA-1:0] y_a = '0, x_a = '0, res_a;
  logic start_b = 1'b0, inv_b = 1'b0, busy_b, done_b, err_b;
  logic [MB-1:0] y_b = '0, x_b = '0, res_b;
`ifdef GF2M_DIVIDER_CYCLE_COUNT_EN
  logic [5:0] cyc_a;
  logic [9:0] cyc_b;
`endif
  int cyc = 0, n_cmp = 0, n_fail = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  logic [W-1:0] tx, ty, scr;
  logic tiv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gf2m_divider #(.M(MA), .STEPS(SA)) dut_a (
    .clk(clk), .reset(rst), .start(start_a), .inv(inv_a), .poly(PA), .y(y_a), .x(x_a),
    .busy(busy_a), .done(done_a), .err(err_a), .result(res_a)
`ifdef GF2M_DIVIDER_CYCLE_COUNT_EN
    , .cycles(cyc_a)
`endif
  );
  gf2m_divider #(.M(MB), .STEPS(SB)) dut_b (
    .clk(clk), .reset(rst), .start(start_b), .inv(inv_b), .poly(PB), .y(y_b), .x(x_b),
    .busy(busy_b), .done(done_b), .err(err_b), .result(res_b)
`ifdef GF2M_DIVIDER_CYCLE_COUNT_EN
    , .cycles(cyc_b)
`endif
  );

  function automatic logic [W-1:0] gmul(input logic [W-1:0] p, q, f, input int m);
    logic [W-1:0] r;
    r = '0;
    for (int i = m - 1; i >= 0; i--) begin
      r = r << 1;
      if (r[m]) r ^= f;
      if (q[i]) r ^= p;
    end
    return r;
  endfunction

  // y * x^(2^m - 2), i.e. y times the field inverse of x
  function automatic logic [W-1:0] gdiv(input logic [W-1:0] yy, xx, f, input int m);
    logic [W-1:0] t, r;
    if (xx == '0) return '0;
    t = xx;
    r = W'(1);
    for (int i = 1; i < m; i++) begin
      t = gmul(t, t, f, m);
      r = gmul(r, t, f, m);
    end
    return gmul(yy, r, f, m);
  endfunction

  function automatic logic [W-1:0] rnd(input int m);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < m; k++) r[k] = 1'($urandom);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk_lat(input string nm, input int lat, lo, hi);
    n_cmp++;
    if (lat < lo || lat > hi) begin
      n_fail++;
      $display("FAIL %s: done after %0d cycles, required %0d..%0d", nm, lat, lo, hi);
    end
  endtask

  always @(negedge clk)
    if (!rst && done_a) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL a_unexpected_done: done=1 with nothing pending, required 0");
      end else begin
        ea = qa.pop_front();
        chk("a_result", W'(res_a), ea.ex);
        chk("a_err", W'(err_a), W'(ea.ee));
        chk_lat("a_latency", cyc - ea.t0, ea.lo, ea.hi);
      end
    end

  always @(negedge clk)
    if (!rst && done_b) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL b_unexpected_done: done=1 with nothing pending, required 0");
      end else begin
        eb = qb.pop_front();
        chk("b_result", W'(res_b), eb.ex);
        chk("b_err", W'(err_b), W'(eb.ee));
        chk_lat("b_latency", cyc - eb.t0, eb.lo, eb.hi);
      end
    end

  task automatic issue(input int d, input logic iv, input logic [W-1:0] yy, xx, ex,
                       input logic ee, input int lo, hi);
    @(negedge clk);
    if (d == 0) begin
      inv_a = iv;
      y_a = yy[MA-1:0];
      x_a = xx[MA-1:0];
      start_a = 1'b1;
      qa.push_back('{ex, ee, cyc, lo, hi});
    end else begin
      inv_b = iv;
      y_b = yy[MB-1:0];
      x_b = xx[MB-1:0];
      start_b = 1'b1;
      qb.push_back('{ex, ee, cyc, lo, hi});
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    x_a = MA'($urandom);
    y_a = MA'($urandom);
    scr = rnd(MB);
    x_b = scr[MB-1:0];
    scr = rnd(MB);
    y_b = scr[MB-1:0];
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && qa.size() + qb.size() != 0; i++) @(negedge clk);
    if (qa.size() + qb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", qa.size() + qb.size());
      qa.delete();
      qb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("a_rst_busy", W'(busy_a), '0);
    chk("a_rst_done", W'(done_a), '0);
    chk("a_rst_err", W'(err_a), '0);
    chk("a_rst_result", W'(res_a), '0);
    chk("b_rst_busy", W'(busy_b), '0);
    chk("b_rst_done", W'(done_b), '0);
    chk("b_rst_result", W'(res_b), '0);
    rst = 1'b0;
    @(negedge clk);
    issue(0, 1'b1, rnd(MA), 'h53, 'hCA, 1'b0, 2, HA);
    drain();
    issue(0, 1'b0, 'hCA, 'hCA, 'h01, 1'b0, 2, HA);
    drain();
    issue(0, 1'b0, 'h01, 'hCA, 'h53, 1'b0, 2, HA);
    drain();
    issue(0, 1'b0, 'h77, 'h00, 'h00, 1'b1, 1, 2);
    chk("a_busy_x0", W'(busy_a), '0);
    drain();
    issue(0, 1'b0, 'h57, 'h01, 'h57, 1'b0, 2, 2);
    drain();
    issue(0, 1'b1, 'h00, 'h53, 'hCA, 1'b0, 2, HA);
    @(negedge clk);
    inv_a = 1'b0;
    x_a = '0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    ty = rnd(MB);
    issue(1, 1'b0, ty, W'(1), ty, 1'b0, 2, 2);
    drain();
    issue(1, 1'b0, ty, '0, '0, 1'b1, 1, 2);
    chk("b_busy_x0", W'(busy_b), '0);
    drain();
    for (int i = 0; i < 600; i++) begin
      tx = rnd(MA);
      ty = rnd(MA);
      tiv = $urandom_range(0, 7) == 0;
      issue(0, tiv, ty, tx, gdiv(tiv ? W'(1) : ty, tx, W'(PA), MA), tx == '0, tx == '0 ? 1 : 2, HA);
      drain();
    end
    for (int i = 0; i < 400; i++) begin
      tx = rnd(MB);
      ty = rnd(MB);
      tiv = $urandom_range(0, 7) == 0;
      issue(1, tiv, ty, tx, gdiv(tiv ? W'(1) : ty, tx, W'(PB), MB), tx == '0, tx == '0 ? 1 : 2, HB);
      drain();
    end
    tx = rnd(MB);
    tx[MB-1] = 1'b1;
    ty = rnd(MB);
    issue(1, 1'b0, ty, tx, '0, 1'b0, 2, HB);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("b_abort_busy", W'(busy_b), '0);
    chk("b_abort_done", W'(done_b), '0);
    chk("b_abort_result", W'(res_b), '0);
    chk("a_abort_result", W'(res_a), '0);
    qb.delete();
    rst = 1'b0;
    issue(1, 1'b0, ty, tx, gdiv(ty, tx, W'(PB), MB), 1'b0, 2, HB);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
